// File: rtl/wb_port_arbiter_if.sv
// Core-side request ports plus the Wishbone classic master bus of the port arbiter.
// Per-port fields are packed arrays; port p occupies slice p.
interface wb_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0]                 we_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0][SW-1:0]         be_i;
  logic [NUM_PORTS-1:0]                 ack_o;
  logic [NUM_PORTS-1:0]                 err_o;
  logic [DATA_WIDTH-1:0]                rdata_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [SW-1:0]         wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  wb_ack_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i, wb_data_i, wb_ack_i,
    output ack_o, err_o, rdata_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i, wb_data_i, wb_ack_i,
    input  ack_o, err_o, rdata_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter folding NUM_PORTS core request ports onto one Wishbone classic
// master, with a per-transfer wait timeout that aborts the cycle and flags err_o.
module wb_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  wb_port_arbiter_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

  // Rotate requests so bit 0 is the port at the round-robin pointer.
  logic [2*NUM_PORTS-1:0] req_rot;
  logic                   found;
  int                     off;
  logic [PW-1:0]          pick;
  logic [PW-1:0]          ptr_next;

  assign req_rot  = {bus.req_i, bus.req_i} >> ptr_q;
  assign ptr_next = PW'((int'(grant_q) + 1) % NUM_PORTS);

  always_comb begin
    found = 1'b0;
    off   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    pick = PW'((int'(ptr_q) + off) % NUM_PORTS);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        cyc_d   = 1'b1;
        we_d    = bus.we_i[pick];
        addr_d  = bus.addr_i[pick];
        data_d  = bus.wdata_i[pick];
        sel_d   = bus.be_i[pick];
        cnt_d   = '0;
        state_d = BUS;
      end
      BUS: begin
        // A late ack on the timeout cycle still wins over the abort.
        if (bus.wb_ack_i) begin
          cyc_d          = 1'b0;
          rdata_d        = bus.wb_data_i;
          ack_d[grant_q] = 1'b1;
          ptr_d          = ptr_next;
          state_d        = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cyc_d          = 1'b0;
          err_d[grant_q] = 1'b1;
          ptr_d          = ptr_next;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_addr_o = addr_q;
  assign bus.wb_data_o = data_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.ack_o     = ack_q;
  assign bus.err_o     = err_q;
  assign bus.rdata_o   = rdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares whenever the DUT presents them.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  wb_port_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } gnt_t;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          clen;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad   = 0;

  // slave model controls
  bit          slave_en   = 1'b1;
  bit          no_ack     = 1'b0;
  bit          linger     = 1'b0;
  int          ack_delay  = 0;
  logic [31:0] slave_data = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(int p, bit we, logic [31:0] addr, logic [31:0] data, logic [3:0] be,
                       logic [31:0] rd, bit is_err, int clen, bit want_rsp);
    gnt_t g;
    rsp_t r;
    logic [1:0] m;
    m = 2'b01 << p;
    g.we = we; g.addr = addr; g.data = data; g.sel = be;
    exp_gnt.push_back(g);
    if (want_rsp) begin
      r.ack = is_err ? 2'b00 : m;
      r.err = is_err ? m : 2'b00;
      r.rdata = rd;
      r.clen = clen;
      exp_rsp.push_back(r);
    end
    bif.we_i[p]    = we;
    bif.addr_i[p]  = addr;
    bif.wdata_i[p] = data;
    bif.be_i[p]    = be;
    bif.req_i[p]   = 1'b1;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while ((bif.req_i != 2'b00 || bif.wb_cyc_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s wait_idle actual=busy expected=idle within 200 cycles", nm);
    end
    @(negedge clk);
  endtask

  // Slave: ack ack_delay cycles after cyc; optional stray ack lingering into RESP.
  initial begin
    int cnt;
    bit last;
    cnt = 0;
    last = 1'b0;
    bif.wb_ack_i  = 1'b0;
    bif.wb_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        if (bif.wb_cyc_o && !no_ack) begin
          if (cnt >= ack_delay) begin
            bif.wb_ack_i  = 1'b1;
            bif.wb_data_i = slave_data;
            last = 1'b1;
          end else begin
            bif.wb_ack_i = 1'b0;
            cnt++;
          end
        end else if (linger && last) begin
          bif.wb_ack_i  = 1'b1;
          bif.wb_data_i = 32'hBAD0BAD0;
          last = 1'b0;
          cnt = 0;
        end else begin
          bif.wb_ack_i = 1'b0;
          cnt = 0;
          last = 1'b0;
        end
      end
    end
  end

  // Requesters hold req until their own ack/err pulse.
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (bif.ack_o[p] || bif.err_o[p]) bif.req_i[p] = 1'b0;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_cyc;
    bit          prev_rsp;
    int          clen;
    logic [31:0] cur_addr;
    gnt_t        g;
    rsp_t        r;
    prev_cyc = 1'b0;
    prev_rsp = 1'b0;
    clen = 0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cyc = 1'b0;
        prev_rsp = 1'b0;
        clen = 0;
      end else begin
        if (bif.wb_cyc_o && !prev_cyc) begin
          if (exp_gnt.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant actual=addr %h expected=no grant", bif.wb_addr_o);
          end else begin
            g = exp_gnt.pop_front();
            chk("gnt_we", {31'd0, bif.wb_we_o}, {31'd0, g.we});
            chk("gnt_addr", bif.wb_addr_o, g.addr);
            chk("gnt_data", bif.wb_data_o, g.data);
            chk("gnt_sel", {28'd0, bif.wb_sel_o}, {28'd0, g.sel});
            chk("gnt_stb", {31'd0, bif.wb_stb_o}, 32'd1);
          end
          cur_addr = bif.wb_addr_o;
        end else if (bif.wb_cyc_o) begin
          chk("bus_addr_stable", bif.wb_addr_o, cur_addr);
        end
        if (bif.wb_cyc_o) clen++;
        if ((bif.ack_o | bif.err_o) != 2'b00) begin
          chk("ack_err_exclusive", {30'd0, bif.ack_o & bif.err_o}, 32'd0);
          chk("pulse_single", {31'd0, prev_rsp}, 32'd0);
          if (exp_rsp.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp actual=ack %b err %b expected=none", bif.ack_o, bif.err_o);
          end else begin
            r = exp_rsp.pop_front();
            chk("rsp_ack", {30'd0, bif.ack_o}, {30'd0, r.ack});
            chk("rsp_err", {30'd0, bif.err_o}, {30'd0, r.err});
            if (r.ack != 2'b00) chk("rsp_rdata", bif.rdata_o, r.rdata);
            chk("rsp_cyc_len", clen, r.clen);
          end
          clen = 0;
        end
        prev_cyc = bif.wb_cyc_o;
        prev_rsp = (bif.ack_o | bif.err_o) != 2'b00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req_i = '0; bif.we_i = '0; bif.addr_i = '0; bif.wdata_i = '0; bif.be_i = '0;

    // reset state
    @(negedge clk);
    chk("rst_cyc", {31'd0, bif.wb_cyc_o}, 32'd0);
    chk("rst_ack_err", {28'd0, bif.ack_o, bif.err_o}, 32'd0);
    chk("rst_rdata", bif.rdata_o, 32'd0);
    chk("rst_addr", bif.wb_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // read, ack 2 cycles after cyc
    ack_delay = 2; slave_data = 32'hDEADBEEF;
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    wait_idle("read");
    chk("read_rdata_hold", bif.rdata_o, 32'hDEADBEEF);

    // write on port1, partial byte enables
    ack_delay = 1; slave_data = 32'h55AA55AA;
    issue(1, 1'b1, 32'h8000_0004, 32'h12345678, 4'b0011, 32'h55AA55AA, 1'b0, 2, 1'b1);
    wait_idle("write");

    // minimum latency and next-grant spacing
    ack_delay = 0; slave_data = 32'h11111111;
    issue(0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h11111111, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h11111111, 1'b0, 1, 1'b1);
    @(negedge clk);
    chk("lat_cyc_n", {31'd0, bif.wb_cyc_o}, 32'd1);
    chk("lat_addr_n", bif.wb_addr_o, 32'h200);
    @(negedge clk);
    chk("lat_ack_n1", {30'd0, bif.ack_o}, 32'd1);
    @(negedge clk);
    chk("lat_resp_n2", {31'd0, bif.wb_cyc_o}, 32'd0);
    @(negedge clk);
    chk("lat_cyc_n3", {31'd0, bif.wb_cyc_o}, 32'd1);
    chk("lat_addr_n3", bif.wb_addr_o, 32'h300);
    wait_idle("latency");

    // contention twice: 0,1,0,1
    ack_delay = 1; slave_data = 32'h22222222;
    for (int k = 0; k < 2; k++) begin
      issue(0, 1'b0, 32'h400 + k, 32'h0, 4'hF, 32'h22222222, 1'b0, 2, 1'b1);
      issue(1, 1'b1, 32'h500 + k, 32'hA5A5_0000 + k, 4'b1100, 32'h22222222, 1'b0, 2, 1'b1);
      wait_idle("contention");
    end

    // pointer past port0: simultaneous requests now serve port1 first
    slave_data = 32'h33333333;
    issue(0, 1'b0, 32'h600, 32'h0, 4'hF, 32'h33333333, 1'b0, 2, 1'b1);
    wait_idle("rr_single");
    issue(1, 1'b0, 32'h710, 32'h0, 4'hF, 32'h33333333, 1'b0, 2, 1'b1);
    issue(0, 1'b0, 32'h610, 32'h0, 4'hF, 32'h33333333, 1'b0, 2, 1'b1);
    wait_idle("rr_order");

    // timeout after 16 bus cycles
    no_ack = 1'b1;
    issue(0, 1'b0, 32'hA00, 32'h0, 4'hF, 32'h0, 1'b1, 16, 1'b1);
    wait_idle("timeout");
    no_ack = 1'b0;
    chk("timeout_rdata_hold", bif.rdata_o, 32'h33333333);

    // stray ack in IDLE
    slave_en = 1'b0;
    bif.wb_ack_i = 1'b1; bif.wb_data_i = 32'h0BAD0BAD;
    @(negedge clk);
    chk("stray_idle_ack", {28'd0, bif.ack_o, bif.err_o}, 32'd0);
    chk("stray_idle_cyc", {31'd0, bif.wb_cyc_o}, 32'd0);
    chk("stray_idle_rdata", bif.rdata_o, 32'h33333333);
    bif.wb_ack_i = 1'b0;
    slave_en = 1'b1;
    @(negedge clk);

    // stray ack lingering into RESP
    linger = 1'b1; ack_delay = 0; slave_data = 32'h44444444;
    issue(1, 1'b0, 32'h900, 32'h0, 4'hF, 32'h44444444, 1'b0, 1, 1'b1);
    wait_idle("stray_resp");
    linger = 1'b0;
    chk("stray_resp_rdata", bif.rdata_o, 32'h44444444);

    // reset mid-BUS with pointer at port1
    slave_data = 32'h55555555;
    issue(0, 1'b0, 32'hB00, 32'h0, 4'hF, 32'h55555555, 1'b0, 1, 1'b1);
    wait_idle("pre_reset");
    no_ack = 1'b1;
    issue(1, 1'b1, 32'hC00, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_bus_cyc", {31'd0, bif.wb_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_now_cyc", {31'd0, bif.wb_cyc_o}, 32'd0);
    chk("rst_now_ack_err", {28'd0, bif.ack_o, bif.err_o}, 32'd0);
    chk("rst_now_rdata", bif.rdata_o, 32'd0);
    chk("rst_now_addr", bif.wb_addr_o, 32'd0);
    bif.req_i = '0;
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold_ack_err", {28'd0, bif.ack_o, bif.err_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack_err", {28'd0, bif.ack_o, bif.err_o}, 32'd0);
    slave_data = 32'h66666666;
    issue(0, 1'b0, 32'hD00, 32'h0, 4'hF, 32'h66666666, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 32'hE00, 32'h0, 4'hF, 32'h66666666, 1'b0, 1, 1'b1);
    wait_idle("post_reset");

    chk("gnt_queue_empty", exp_gnt.size(), 32'd0);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
